// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift/rotate sequencer and the ALU decoder.
// Build option: SHIFT_CTRL_ROTATE_EN enables ROL/ROR (two-pass rotates).
package shift_ctrl_pkg;

  localparam int SHIFT_WIDTH = 32;
  localparam int SHIFT_SHW   = 5;

  localparam logic [2:0] SHIFT_OP_SHL = 3'b000;
  localparam logic [2:0] SHIFT_OP_SHR = 3'b001;
  localparam logic [2:0] SHIFT_OP_SRA = 3'b010;
  localparam logic [2:0] SHIFT_OP_ROL = 3'b011;
  localparam logic [2:0] SHIFT_OP_ROR = 3'b100;

`ifdef SHIFT_CTRL_ROTATE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_DONE  = 2'b11
  } shift_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_DONE  = 2'b11
  } shift_state_e;
`endif

  // True for op codes this build can execute.
  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      SHIFT_OP_SHL, SHIFT_OP_SHR, SHIFT_OP_SRA: return 1'b1;
`ifdef SHIFT_CTRL_ROTATE_EN
      SHIFT_OP_ROL, SHIFT_OP_ROR:               return 1'b1;
`else
      SHIFT_OP_ROL, SHIFT_OP_ROR:               return 1'b0;
`endif
      default:                                  return 1'b0;
    endcase
  endfunction

`ifdef SHIFT_CTRL_ROTATE_EN
  // True for the two-pass rotate ops.
  function automatic logic op_is_rotate(input logic [2:0] op);
    case (op)
      SHIFT_OP_ROL, SHIFT_OP_ROR: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction
`endif

endpackage

// File: rtl/shift_ctrl.sv
// Sequencer for the shared barrel shifter: accepts shift/rotate requests,
// drives the shifter through one or two passes and returns the result.
// Build option: SHIFT_CTRL_ROTATE_EN adds ROL/ROR as left|right pass pairs;
// without it those op codes report illegal.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int SHW   = SHIFT_SHW
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iD,
  input  logic [SHW-1:0]   iShamt,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oD,
  output logic             oIllegal,
  output logic [WIDTH-1:0] oShD,
  output logic [SHW-1:0]   oShShamt,
  output logic             oShnLeft,
  output logic             oShnArith,
  input  logic [WIDTH-1:0] iShRes
);

  shift_state_e     state_r;
  shift_state_e     state_s;

  logic             busy_s;
  logic             done_s;
  logic             illegal_s;
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] shd_s;
  logic [SHW-1:0]   shamt_s;
  logic             nleft_s;
  logic             narith_s;

`ifdef SHIFT_CTRL_ROTATE_EN
  // Second-pass amount is (WIDTH - n) wrapped to SHW bits, so n = 0 gives 0.
  localparam logic [SHW-1:0] WRAP_AMT = SHW'(WIDTH);

  logic [2:0]       op_r;
  logic [2:0]       op_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
`endif

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          if (op_is_legal(iOp)) begin
            state_s = ST_PASS1;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PASS1: begin
`ifdef SHIFT_CTRL_ROTATE_EN
        if (op_is_rotate(op_r)) begin
          state_s = ST_PASS2;
        end else begin
          state_s = ST_DONE;
        end
`else
        state_s = ST_DONE;
`endif
      end
`ifdef SHIFT_CTRL_ROTATE_EN
      ST_PASS2: state_s = ST_DONE;
`endif
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, shifter controls and accumulator.
  always_comb begin
    busy_s    = (state_s != ST_IDLE);
    done_s    = 1'b0;
    illegal_s = 1'b0;
    d_s       = oD;
    shd_s     = oShD;
    shamt_s   = oShShamt;
    nleft_s   = oShnLeft;
    narith_s  = oShnArith;
`ifdef SHIFT_CTRL_ROTATE_EN
    op_s      = op_r;
    acc_s     = acc_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (iStart) begin
          d_s = {WIDTH{1'b0}};
`ifdef SHIFT_CTRL_ROTATE_EN
          op_s = iOp;
`endif
          if (op_is_legal(iOp)) begin
            // First pass: ROL is a left shift, ROR a logical right shift.
            shd_s    = iD;
            shamt_s  = iShamt;
            nleft_s  = (iOp == SHIFT_OP_SHL) || (iOp == SHIFT_OP_ROL);
            narith_s = (iOp != SHIFT_OP_SRA);
          end else begin
            done_s    = 1'b1;
            illegal_s = 1'b1;
          end
        end else begin
          done_s = 1'b0;
        end
      end
      ST_PASS1: begin
`ifdef SHIFT_CTRL_ROTATE_EN
        acc_s = iShRes;
        if (op_is_rotate(op_r)) begin
          // Same data, opposite direction, logical, complementary amount.
          nleft_s  = ~oShnLeft;
          narith_s = 1'b1;
          shamt_s  = WRAP_AMT - oShShamt;
        end else begin
          d_s    = iShRes;
          done_s = 1'b1;
        end
`else
        d_s    = iShRes;
        done_s = 1'b1;
`endif
      end
`ifdef SHIFT_CTRL_ROTATE_EN
      ST_PASS2: begin
        acc_s  = acc_r | iShRes;
        d_s    = acc_r | iShRes;
        done_s = 1'b1;
      end
`endif
      ST_DONE: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Output, shifter-control and accumulator registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oIllegal  <= 1'b0;
      oD        <= {WIDTH{1'b0}};
      oShD      <= {WIDTH{1'b0}};
      oShShamt  <= {SHW{1'b0}};
      oShnLeft  <= 1'b0;
      oShnArith <= 1'b1;
`ifdef SHIFT_CTRL_ROTATE_EN
      op_r      <= 3'b000;
      acc_r     <= {WIDTH{1'b0}};
`endif
    end else begin
      oBusy     <= busy_s;
      oDone     <= done_s;
      oIllegal  <= illegal_s;
      oD        <= d_s;
      oShD      <= shd_s;
      oShShamt  <= shamt_s;
      oShnLeft  <= nleft_s;
      oShnArith <= narith_s;
`ifdef SHIFT_CTRL_ROTATE_EN
      op_r      <= op_s;
      acc_r     <= acc_s;
`endif
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed scoreboard bench for shift_ctrl with a behavioural barrel shifter
// beside it. Honours SHIFT_CTRL_ROTATE_EN the same way as the design.
module tb_shift_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] d;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk_s;
  logic        rst_s;
  logic        start_s;
  logic [2:0]  op_s;
  logic [31:0] d_s;
  logic [4:0]  shamt_s;
  logic        busy_s;
  logic        done_s;
  logic [31:0] res_s;
  logic        illegal_s;
  logic [31:0] sh_d_s;
  logic [4:0]  sh_shamt_s;
  logic        sh_nleft_s;
  logic        sh_narith_s;
  logic [31:0] sh_res_s;

  int   checks;
  int   errors;
  exp_t sb[$];

  shift_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .iClk      (clk_s),
    .iRst      (rst_s),
    .iStart    (start_s),
    .iOp       (op_s),
    .iD        (d_s),
    .iShamt    (shamt_s),
    .oBusy     (busy_s),
    .oDone     (done_s),
    .oD        (res_s),
    .oIllegal  (illegal_s),
    .oShD      (sh_d_s),
    .oShShamt  (sh_shamt_s),
    .oShnLeft  (sh_nleft_s),
    .oShnArith (sh_narith_s),
    .iShRes    (sh_res_s)
  );

  // Behavioural barrel shifter standing in for the datapath instance.
  always_comb begin
    sh_res_s = 32'h0000_0000;
    if (sh_nleft_s) begin
      sh_res_s = sh_d_s << sh_shamt_s;
    end else if (sh_narith_s) begin
      sh_res_s = sh_d_s >> sh_shamt_s;
    end else begin
      sh_res_s = $signed(sh_d_s) >>> sh_shamt_s;
    end
  end

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic ref_rot(input logic [2:0] op);
`ifdef SHIFT_CTRL_ROTATE_EN
    return (op == 3'b011) || (op == 3'b100);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic ref_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || ref_rot(op);
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] d,
                                          input logic [4:0] n);
    logic [63:0] dd;
    dd = {d, d};
    if (!ref_legal(op)) return 32'h0000_0000;
    case (op)
      3'b000:  return d << n;
      3'b001:  return d >> n;
      3'b010:  return $signed(d) >>> n;
      3'b011:  begin dd = dd << n; return dd[63:32]; end
      3'b100:  begin dd = dd >> n; return dd[31:0]; end
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy_s, 1'b0);
    chk1({tag, "_done"}, done_s, 1'b0);
    chk1({tag, "_illegal"}, illegal_s, 1'b0);
    chk({tag, "_od"}, res_s, 32'h0000_0000);
    chk({tag, "_shd"}, sh_d_s, 32'h0000_0000);
    chk({tag, "_shamt"}, {27'd0, sh_shamt_s}, 32'h0000_0000);
    chk1({tag, "_nleft"}, sh_nleft_s, 1'b0);
    chk1({tag, "_narith"}, sh_narith_s, 1'b1);
  endtask

  // Drive a one-cycle start and push the expected outcome.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] d,
                       input logic [4:0] n);
    exp_t e;
    e.tag = tag;
    e.d   = ref_res(op, d, n);
    e.ill = !ref_legal(op);
    e.lat = e.ill ? 1 : (ref_rot(op) ? 3 : 2);
    sb.push_back(e);
    start_s = 1'b1;
    op_s    = op;
    d_s     = d;
    shamt_s = n;
    tick();
    start_s = 1'b0;
    chk1({tag, "_busy1"}, busy_s, 1'b1);
    if (!e.ill) begin
      chk({tag, "_shd"}, sh_d_s, d);
      chk({tag, "_shamt"}, {27'd0, sh_shamt_s}, {27'd0, n});
      chk1({tag, "_nleft"}, sh_nleft_s, (op == 3'b000) || (op == 3'b011));
      chk1({tag, "_narith"}, sh_narith_s, op != 3'b010);
    end else begin
      chk1({tag, "_done_now"}, done_s, 1'b1);
    end
  endtask

  // Wait (bounded) for oDone, compare against the scoreboard, check pulse ends.
  task automatic wait_done(input int lat0);
    int   lat;
    exp_t e;
    lat = lat0;
    while (done_s !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    chk1("done_seen", done_s, 1'b1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 entries expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_od"}, res_s, e.d);
      chk1({e.tag, "_illegal"}, illegal_s, e.ill);
      chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk1({e.tag, "_busy_done"}, busy_s, 1'b1);
    end else begin
      lat = 0;
    end
    tick();
    chk1("done_pulse_end", done_s, 1'b0);
    chk1("illegal_pulse_end", illegal_s, 1'b0);
    chk1("busy_idle", busy_s, 1'b0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_s   = 1'b1;
    start_s = 1'b0;
    op_s    = 3'b000;
    d_s     = 32'h0000_0000;
    shamt_s = 5'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_s = 1'b0;
    tick();
    check_reset_outputs("after_reset");

    issue("shl31", 3'b000, 32'h0000_0001, 5'd31);
    wait_done(1);
    issue("sra16", 3'b010, 32'h8000_0000, 5'd16);
    wait_done(1);
    issue("shr16", 3'b001, 32'h8000_0000, 5'd16);
    wait_done(1);
    issue("shl0", 3'b000, 32'hDEAD_BEEF, 5'd0);
    wait_done(1);
    issue("ror8", 3'b100, 32'h1234_5678, 5'd8);
    wait_done(1);
    issue("rol0", 3'b011, 32'h1234_5678, 5'd0);
    wait_done(1);
    issue("rol4", 3'b011, 32'h8765_4321, 5'd4);
    wait_done(1);
    issue("ill111", 3'b111, 32'hFFFF_FFFF, 5'd3);
    wait_done(1);
    // Result is held in idle.
    tick();
    chk("hold_od", res_s, 32'h0000_0000);

    // A second start during PASS1 is ignored; only one done appears.
    issue("busy_start", 3'b000, 32'h0000_0005, 5'd4);
    start_s = 1'b1;
    op_s    = 3'b001;
    d_s     = 32'hFFFF_0000;
    shamt_s = 5'd1;
    tick();
    start_s = 1'b0;
    wait_done(2);
    for (int i = 0; i < 4; i++) begin
      chk1("no_extra_done", done_s, 1'b0);
      tick();
    end

    // Back-to-back: start in the first idle cycle after done.
    issue("b2b_a", 3'b001, 32'hF000_000F, 5'd2);
    wait_done(1);
    issue("b2b_b", 3'b010, 32'hF000_000F, 5'd2);
    wait_done(1);

    // Reset mid-operation aborts with no done.
`ifdef SHIFT_CTRL_ROTATE_EN
    issue("abort", 3'b011, 32'hF0F0_000F, 5'd4);
    tick();
`else
    issue("abort", 3'b010, 32'hF0F0_000F, 5'd4);
`endif
    rst_s = 1'b1;
    #1;
    check_reset_outputs("abort_rst");
    sb.delete();
    tick();
    rst_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("abort_no_done", done_s, 1'b0);
    end
    issue("post_abort", 3'b001, 32'h1234_5678, 5'd4);
    wait_done(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
